// File: rtl/rx_stage_4b.sv
// Nibble-serial instruction receiver: assembles op/a1/a2/b1/b2 frames and holds
// each frame until the decode stage accepts it. Also resyncs, times out and counts frames.
module rx_stage_4b #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       alu_ready_in,
  output logic       rx_valid_out,
  output logic [3:0] op,
  output logic [3:0] a1,
  output logic [3:0] a2,
  output logic [3:0] b1,
  output logic [3:0] b2,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t          state_reg, state_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      tmo_reg, tmo_next;
  logic            err_reg, err_next;
  logic [7:0]      cnt_reg, cnt_next;
  logic            accept;
  logic            timeout_hit;
  logic            wr_field;
  logic [2:0]      wr_sel;
  logic [4:0]      field_we;
  logic [4:0][3:0] field_q;

  assign accept      = in_valid & in_ready;
  assign timeout_hit = (TMO_LIMIT != 8'd0) && ((tmo_reg + 8'd1) == TMO_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && in_start) state_next = COLLECT;
      end
      COLLECT: begin
        if (accept && !in_start && idx_reg == 3'd4) state_next = HOLD;
        else if (!accept && timeout_hit)            state_next = IDLE;
      end
      HOLD: begin
        if (alu_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready     = rst_n & (state_reg != HOLD);
    rx_valid_out = (state_reg == HOLD);
  end

  // Datapath control: index, timeout, error and frame counter
  always_comb begin
    idx_next = idx_reg;
    tmo_next = tmo_reg;
    err_next = 1'b0;
    cnt_next = cnt_reg;
    wr_field = 1'b0;
    wr_sel   = 3'd0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_start) begin
            wr_field = 1'b1;
            idx_next = 3'd1;
            tmo_next = 8'd0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          tmo_next = 8'd0;
          wr_field = 1'b1;
          if (in_start) begin
            err_next = 1'b1;
            idx_next = 3'd1;
          end else begin
            wr_sel   = idx_reg;
            // Index drops back to 0 on frame completion so it never exceeds 4
            idx_next = (idx_reg == 3'd4) ? 3'd0 : idx_reg + 3'd1;
          end
        end else if (timeout_hit) begin
          err_next = 1'b1;
          tmo_next = 8'd0;
          idx_next = 3'd0;
        end else if (TMO_LIMIT != 8'd0) begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      HOLD: begin
        if (alu_ready_in) cnt_next = cnt_reg + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= 3'd0;
      tmo_reg <= 8'd0;
      err_reg <= 1'b0;
      cnt_reg <= 8'd0;
    end else begin
      idx_reg <= idx_next;
      tmo_reg <= tmo_next;
      err_reg <= err_next;
      cnt_reg <= cnt_next;
    end
  end

  // One register per field; field 0 is op, fields 1..4 are a1, a2, b1, b2
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_field
      logic [3:0] nib_reg;
      assign field_we[gi] = wr_field && (wr_sel == 3'(gi));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          nib_reg <= 4'd0;
        end else if (field_we[gi]) begin
          nib_reg <= in_data;
        end
      end
      assign field_q[gi] = nib_reg;
    end
  endgenerate

  assign op        = field_q[0];
  assign a1        = field_q[1];
  assign a2        = field_q[2];
  assign b1        = field_q[3];
  assign b2        = field_q[4];
  assign frame_err = err_reg;
  assign frame_cnt = cnt_reg;

endmodule

// File: tb/tb_rx_stage_4b.sv
// Directed bench for rx_stage_4b with TIMEOUT_CYCLES=4; every expected value is hand-computed.
module tb_rx_stage_4b;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_start;
  logic [3:0] in_data;
  logic       in_ready;
  logic       alu_ready_in;
  logic       rx_valid_out;
  logic [3:0] op, a1, a2, b1, b2;
  logic       frame_err;
  logic [7:0] frame_cnt;

  int vec_cnt;
  int miscompare_cnt;

  rx_stage_4b #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_start     (in_start),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .alu_ready_in (alu_ready_in),
    .rx_valid_out (rx_valid_out),
    .op           (op),
    .a1           (a1),
    .a2           (a2),
    .b1           (b1),
    .b2           (b2),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // All stimulus changes happen 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic start, input logic [3:0] data);
    in_valid = 1'b1;
    in_start = start;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] o, input logic [3:0] x1, input logic [3:0] x2,
                            input logic [3:0] x3, input logic [3:0] x4);
    send(1'b1, o);
    send(1'b0, x1);
    send(1'b0, x2);
    send(1'b0, x3);
    send(1'b0, x4);
  endtask

  task automatic check_fields(input string tag, input logic [3:0] o, input logic [3:0] x1,
                              input logic [3:0] x2, input logic [3:0] x3, input logic [3:0] x4);
    chk({tag, ".valid"}, 32'(rx_valid_out), 32'd1);
    chk({tag, ".op"}, 32'(op), 32'(o));
    chk({tag, ".a1"}, 32'(a1), 32'(x1));
    chk({tag, ".a2"}, 32'(a2), 32'(x2));
    chk({tag, ".b1"}, 32'(b1), 32'(x3));
    chk({tag, ".b2"}, 32'(b2), 32'(x4));
  endtask

  task automatic handoff(input string tag, input logic [7:0] exp_cnt);
    alu_ready_in = 1'b1;
    tick();
    alu_ready_in = 1'b0;
    chk({tag, ".valid_low"}, 32'(rx_valid_out), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".cnt"}, 32'(frame_cnt), 32'(exp_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".valid"}, 32'(rx_valid_out), 32'd0);
    chk({tag, ".fields"}, {12'd0, op, a1, a2, b1, b2}, 32'd0);
    chk({tag, ".err"}, 32'(frame_err), 32'd0);
    chk({tag, ".cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_start       = 1'b0;
    in_data        = 4'd0;
    alu_ready_in   = 1'b0;

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    // Basic back-to-back frame and handoff
    send_frame(4'h3, 4'h1, 4'h2, 4'h4, 4'h8);
    check_fields("basic", 4'h3, 4'h1, 4'h2, 4'h4, 4'h8);
    chk("basic.in_ready_hold", 32'(in_ready), 32'd0);
    handoff("basic.ho", 8'd1);

    // Stalled decode stage with upstream pushing new data
    send_frame(4'hA, 4'hB, 4'hC, 4'hD, 4'hE);
    in_valid = 1'b1;
    in_start = 1'b0;
    in_data  = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk("stall.err", 32'(frame_err), 32'd0);
    end
    check_fields("stall", 4'hA, 4'hB, 4'hC, 4'hD, 4'hE);
    alu_ready_in = 1'b1;
    tick();
    alu_ready_in = 1'b0;
    in_valid     = 1'b0;
    chk("stall.ho.valid", 32'(rx_valid_out), 32'd0);
    chk("stall.ho.cnt", 32'(frame_cnt), 32'd2);
    chk("stall.ho.err", 32'(frame_err), 32'd0);

    // Resync: a start nibble mid-frame restarts it
    send(1'b1, 4'h5);
    send(1'b0, 4'h6);
    chk("resync.pre_err", 32'(frame_err), 32'd0);
    send(1'b1, 4'h9);
    chk("resync.err", 32'(frame_err), 32'd1);
    send(1'b0, 4'h1);
    chk("resync.err_clear", 32'(frame_err), 32'd0);
    send(1'b0, 4'h2);
    send(1'b0, 4'h3);
    send(1'b0, 4'h7);
    check_fields("resync", 4'h9, 4'h1, 4'h2, 4'h3, 4'h7);
    handoff("resync.ho", 8'd3);

    // Timeout after 4 idle cycles inside a frame
    send(1'b1, 4'h7);
    send(1'b0, 4'h1);
    send(1'b0, 4'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo.wait_err", 32'(frame_err), 32'd0);
      chk("tmo.wait_valid", 32'(rx_valid_out), 32'd0);
    end
    tick();
    chk("tmo.err", 32'(frame_err), 32'd1);
    chk("tmo.valid", 32'(rx_valid_out), 32'd0);
    tick();
    chk("tmo.err_clear", 32'(frame_err), 32'd0);
    send_frame(4'hC, 4'h4, 4'h3, 4'h2, 4'h1);
    check_fields("tmo.fresh", 4'hC, 4'h4, 4'h3, 4'h2, 4'h1);
    handoff("tmo.ho", 8'd4);

    // Non-start nibble in IDLE is rejected; a second one proves IDLE was kept
    send(1'b0, 4'h6);
    chk("idle_err.1", 32'(frame_err), 32'd1);
    send(1'b0, 4'h6);
    chk("idle_err.2", 32'(frame_err), 32'd1);
    tick();
    chk("idle_err.clear", 32'(frame_err), 32'd0);

    // Drive frame_cnt from 4 through 255 and back to 0
    for (int i = 0; i < 251; i++) begin
      send_frame(4'(i), 4'h1, 4'h2, 4'h3, 4'h4);
      alu_ready_in = 1'b1;
      tick();
      alu_ready_in = 1'b0;
    end
    chk("wrap.255", 32'(frame_cnt), 32'd255);
    send_frame(4'h2, 4'h1, 4'h2, 4'h3, 4'h4);
    handoff("wrap.ho", 8'd0);

    // Asynchronous reset mid-COLLECT
    send_frame(4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
    handoff("pre_rst.ho", 8'd1);
    send(1'b1, 4'hD);
    send(1'b0, 4'hE);
    send(1'b0, 4'hF);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_collect");
    #1 rst_n = 1'b1;
    tick();
    send_frame(4'h6, 4'h5, 4'h4, 4'h3, 4'h2);
    check_fields("post_rst1", 4'h6, 4'h5, 4'h4, 4'h3, 4'h2);

    // Asynchronous reset mid-HOLD
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_hold");
    #1 rst_n = 1'b1;
    tick();
    send_frame(4'hB, 4'hA, 4'h9, 4'h8, 4'h7);
    check_fields("post_rst2", 4'hB, 4'hA, 4'h9, 4'h8, 4'h7);
    handoff("post_rst2.ho", 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
